// File: rtl/raster_stamp_dispatch_pkg.sv
// Shared raster types, sizes and the pos_mask packing used by the dispatcher and the CSR unit.
package raster_stamp_dispatch_pkg;

    localparam int unsigned RASTER_DIM_BITS      = 12;
    localparam int unsigned RASTER_PID_BITS      = 8;
    localparam int unsigned RASTER_BCOORD_BITS   = 16;
    localparam int unsigned RASTER_POS_BITS      = RASTER_DIM_BITS - 1;
    localparam int unsigned RASTER_POS_MASK_BITS = 4 + 2 * RASTER_POS_BITS;

    typedef logic [2:0][RASTER_BCOORD_BITS-1:0] raster_bcoords_t;

    typedef struct packed {
        logic [RASTER_POS_BITS-1:0] pos_x;
        logic [RASTER_POS_BITS-1:0] pos_y;
        logic [3:0]                 mask;
        raster_bcoords_t            bcoords;
        logic [RASTER_PID_BITS-1:0] pid;
    } raster_stamp_t;

    typedef struct packed {
        raster_bcoords_t bcoords;
        logic [31:0]     pos_mask;
    } raster_csrs_t;

    typedef enum logic [1:0] {StIdle, StWait, StResp} disp_state_e;

    function automatic logic [31:0] raster_pack_pos_mask(raster_stamp_t s);
        logic [31:0] r;
        r = '0;
        r[3:0] = s.mask;
        r[4 +: RASTER_POS_BITS] = s.pos_x;
        r[4 + RASTER_POS_BITS +: RASTER_POS_BITS] = s.pos_y;
        return r;
    endfunction

endpackage

// File: rtl/raster_stamp_dispatch_if.sv
// Stamp input, warp fetch request and per-lane response bundle of the stamp dispatcher.
interface raster_stamp_dispatch_if
    import raster_stamp_dispatch_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TAG_WIDTH = 8
);

    logic                                         stamp_valid;
    raster_stamp_t                                stamp_data;
    logic                                         stamp_ready;
    logic                                         raster_done;
    logic                                         req_valid;
    logic [NUM_LANES-1:0]                         req_tmask;
    logic [TAG_WIDTH-1:0]                         req_tag;
    logic                                         req_ready;
    logic                                         rsp_valid;
    logic [NUM_LANES-1:0]                         rsp_tmask;
    raster_csrs_t [NUM_LANES-1:0]                 rsp_csrs;
    logic [NUM_LANES-1:0][RASTER_PID_BITS-1:0]    rsp_pids;
    logic [TAG_WIDTH-1:0]                         rsp_tag;
    logic                                         rsp_ready;
    logic                                         empty;

    modport master (
        output stamp_valid, stamp_data, raster_done, req_valid, req_tmask, req_tag, rsp_ready,
        input  stamp_ready, req_ready, rsp_valid, rsp_tmask, rsp_csrs, rsp_pids, rsp_tag, empty
    );

    modport slave (
        input  stamp_valid, stamp_data, raster_done, req_valid, req_tmask, req_tag, rsp_ready,
        output stamp_ready, req_ready, rsp_valid, rsp_tmask, rsp_csrs, rsp_pids, rsp_tag, empty
    );

endinterface

// File: rtl/raster_stamp_queue.sv
// Circular stamp buffer: single push, NUM_LANES parallel reads at head+i, variable pop count.
module raster_stamp_queue
    import raster_stamp_dispatch_pkg::*;
#(
    parameter int unsigned QUEUE_SIZE = 16,
    parameter int unsigned NUM_LANES  = 4,
    localparam int unsigned AW = $clog2(QUEUE_SIZE),
    localparam int unsigned CW = $clog2(QUEUE_SIZE + 1),
    localparam int unsigned PW = $clog2(NUM_LANES + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  raster_stamp_t                 push_data,
    input  logic [PW-1:0]                 pop_cnt,
    output logic [CW-1:0]                 count,
    output raster_stamp_t [NUM_LANES-1:0] rd_data
);

    raster_stamp_t mem_q [QUEUE_SIZE];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          push_en;

    assign push_en = push & (count_q != CW'(QUEUE_SIZE));
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[tail_q] <= push_data;
        end
    end

    // Pointer arithmetic wraps by truncation since QUEUE_SIZE is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                tail_q <= tail_q + AW'(1);
            end
            head_q  <= head_q + AW'(pop_cnt);
            count_q <= count_q + CW'(push_en) - CW'(pop_cnt);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            rd_data[i] = mem_q[head_q + AW'(i)];
        end
    end

endmodule

// File: rtl/raster_stamp_dispatch.sv
// Hands buffered quad stamps to warp fetch requests, one stamp per active lane in lane order.
module raster_stamp_dispatch
    import raster_stamp_dispatch_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned QUEUE_SIZE = 16,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    raster_stamp_dispatch_if.slave bus
);

    localparam int unsigned CW = $clog2(QUEUE_SIZE + 1);
    localparam int unsigned PW = $clog2(NUM_LANES + 1);

    if (RASTER_POS_MASK_BITS > 32) begin : g_pos_mask_chk
        $error("pos_mask packing does not fit in 32 bits");
    end
    if ((QUEUE_SIZE < NUM_LANES) || ((QUEUE_SIZE & (QUEUE_SIZE - 1)) != 0)) begin : g_queue_chk
        $error("QUEUE_SIZE must be a power of two no smaller than NUM_LANES");
    end

    disp_state_e                               state_q;
    logic                                      req_ready_q, rsp_valid_q;
    logic [NUM_LANES-1:0]                      tmask_q, rsp_tmask_q;
    logic [TAG_WIDTH-1:0]                      tag_q, rsp_tag_q;
    logic [PW-1:0]                             need_q;
    raster_csrs_t [NUM_LANES-1:0]              rsp_csrs_q;
    logic [NUM_LANES-1:0][RASTER_PID_BITS-1:0] rsp_pids_q;

    logic [CW-1:0]                             count, need_ext, take;
    logic [PW-1:0]                             req_need, pop_cnt, rank;
    logic                                      dispatch;
    raster_stamp_t [NUM_LANES-1:0]             rd_data;
    logic [NUM_LANES-1:0]                      disp_tmask;
    raster_csrs_t [NUM_LANES-1:0]              disp_csrs;
    logic [NUM_LANES-1:0][RASTER_PID_BITS-1:0] disp_pids;

    raster_stamp_queue #(
        .QUEUE_SIZE (QUEUE_SIZE),
        .NUM_LANES  (NUM_LANES)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.stamp_valid & bus.stamp_ready),
        .push_data (bus.stamp_data),
        .pop_cnt   (pop_cnt),
        .count     (count),
        .rd_data   (rd_data)
    );

    assign bus.stamp_ready = reset_n & (count != CW'(QUEUE_SIZE));
    assign bus.empty       = bus.raster_done & (count == '0);
    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_tmask   = rsp_tmask_q;
    assign bus.rsp_csrs    = rsp_csrs_q;
    assign bus.rsp_pids    = rsp_pids_q;
    assign bus.rsp_tag     = rsp_tag_q;

    always_comb begin
        req_need = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            req_need = req_need + PW'(bus.req_tmask[l]);
        end
    end

    // Partial dispatch once the generator is done: hand out whatever is queued.
    assign need_ext = CW'(need_q);
    assign take     = (need_ext <= count) ? need_ext : count;
    assign dispatch = (state_q == StWait) && ((count >= need_ext) || bus.raster_done);
    assign pop_cnt  = dispatch ? PW'(take) : '0;

    always_comb begin
        rank       = '0;
        disp_tmask = '0;
        disp_csrs  = '0;
        disp_pids  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (tmask_q[l]) begin
                for (int j = 0; j < NUM_LANES; j++) begin
                    if ((rank == PW'(j)) && (CW'(rank) < take)) begin
                        disp_tmask[l]         = 1'b1;
                        disp_csrs[l].bcoords  = rd_data[j].bcoords;
                        disp_csrs[l].pos_mask = raster_pack_pos_mask(rd_data[j]);
                        disp_pids[l]          = rd_data[j].pid;
                    end
                end
                rank = rank + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            tmask_q     <= '0;
            tag_q       <= '0;
            need_q      <= '0;
            rsp_tmask_q <= '0;
            rsp_csrs_q  <= '0;
            rsp_pids_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        tmask_q     <= bus.req_tmask;
                        tag_q       <= bus.req_tag;
                        need_q      <= req_need;
                        req_ready_q <= 1'b0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (dispatch) begin
                        rsp_tmask_q <= disp_tmask;
                        rsp_csrs_q  <= disp_csrs;
                        rsp_pids_q  <= disp_pids;
                        rsp_tag_q   <= tag_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
